// File: rtl/mc_core_if.sv
// rtl/mc_core_if.sv - data memory req/ack bus between mc_core and its data memory
//
// Purpose: carries one load/store transaction at a time. The master raises
//          dmem_req with dmem_we/dmem_addr/dmem_wdata held stable until it
//          samples dmem_ack; dmem_rdata is valid in the ack cycle.
// Signals: dmem_req, dmem_we, dmem_addr[AW], dmem_wdata[DW]  master -> slave
//          dmem_rdata[DW], dmem_ack                          slave -> master
interface mc_core_if #(
  parameter int DW = 8,
  parameter int AW = 8
);
  logic          dmem_req;
  logic          dmem_we;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata;
  logic [DW-1:0] dmem_rdata;
  logic          dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/mc_core.sv
// rtl/mc_core.sv - multi-cycle accumulator core with sync-read ROM and req/ack data memory
//
// Purpose: FETCH/EXEC/MEM/HALTED sequencer around a register file whose r0
//          is the accumulator. Plain instructions take 2 cycles; LD/ST take
//          2 cycles plus however long the data memory holds off dmem_ack.
// Ports:   CLK        clock, rising edge
//          start      synchronous active-high reset
//          imem_addr  instruction address (= pc)
//          imem_data  instruction word, valid one cycle after imem_addr
//          dmem       mc_core_if master: data memory transaction
//          halt       sticky, set once HALT has executed
//          flag       F flag
//          pc         program counter
//          retired    completed-instruction count, saturating
module mc_core #(
  parameter int DW  = 8,
  parameter int AW  = 8,
  parameter int OPW = 5,
  parameter int RW  = 4,
  parameter int CW  = 16
) (
  input  logic               CLK,
  input  logic               start,
  output logic [AW-1:0]      imem_addr,
  input  logic [OPW+RW-1:0]  imem_data,
  mc_core_if.master          dmem,
  output logic               halt,
  output logic               flag,
  output logic [AW-1:0]      pc,
  output logic [CW-1:0]      retired
);
  localparam int NREG = 2 ** RW;

  localparam logic [OPW-1:0] OP_HALT = OPW'(0);
  localparam logic [OPW-1:0] OP_LDI  = OPW'(1);
  localparam logic [OPW-1:0] OP_MOV  = OPW'(2);
  localparam logic [OPW-1:0] OP_STR  = OPW'(3);
  localparam logic [OPW-1:0] OP_ADD  = OPW'(4);
  localparam logic [OPW-1:0] OP_ADC  = OPW'(5);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(6);
  localparam logic [OPW-1:0] OP_AND  = OPW'(7);
  localparam logic [OPW-1:0] OP_OR   = OPW'(8);
  localparam logic [OPW-1:0] OP_XOR  = OPW'(9);
  localparam logic [OPW-1:0] OP_SHL  = OPW'(10);
  localparam logic [OPW-1:0] OP_SHR  = OPW'(11);
  localparam logic [OPW-1:0] OP_CMP  = OPW'(12);
  localparam logic [OPW-1:0] OP_LD   = OPW'(13);
  localparam logic [OPW-1:0] OP_ST   = OPW'(14);
  localparam logic [OPW-1:0] OP_BF   = OPW'(15);
  localparam logic [OPW-1:0] OP_JMP  = OPW'(16);

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALTED} state_t;

  state_t         state_q;
  logic [AW-1:0]  pc_q;
  logic [DW-1:0]  regs_q [NREG];
  logic           f_q;
  logic           halt_q;
  logic [CW-1:0]  ret_q;
  logic           req_q;
  logic           we_q;
  logic [AW-1:0]  addr_q;
  logic [DW-1:0]  wdata_q;

  logic [OPW-1:0] opc;
  logic [RW-1:0]  n;
  logic [DW-1:0]  r0;
  logic [DW-1:0]  rn;
  logic [AW-1:0]  rn_addr;
  logic [AW-1:0]  br_off;
  logic [CW-1:0]  ret_inc;

  logic [DW-1:0]  r0_d;
  logic           f_d;
  logic [AW-1:0]  pc_d;
  logic [DW:0]    sum;

  assign opc     = imem_data[OPW+RW-1:RW];
  assign n       = imem_data[RW-1:0];
  assign r0      = regs_q[0];
  assign rn      = regs_q[n];
  // Register value used as an address: truncated or zero-extended to AW.
  assign rn_addr = AW'(rn);
  // Branch displacement is the low RW bits of rn, sign-extended.
  assign br_off  = AW'($signed(rn[RW-1:0]));
  assign ret_inc = (ret_q == '1) ? ret_q : ret_q + 1'b1;

  // Next accumulator, flag and pc for the non-memory instructions.
  always_comb begin
    r0_d = r0;
    f_d  = f_q;
    pc_d = pc_q + 1'b1;
    sum  = '0;
    case (opc)
      OP_HALT: pc_d = pc_q;
      OP_LDI:  r0_d = DW'(n);
      OP_MOV:  r0_d = rn;
      OP_ADD: begin
        sum         = {1'b0, r0} + {1'b0, rn};
        {f_d, r0_d} = sum;
      end
      OP_ADC: begin
        sum         = {1'b0, r0} + {1'b0, rn} + {{DW{1'b0}}, f_q};
        {f_d, r0_d} = sum;
      end
      OP_SUB: begin
        // Bit DW of the widened difference is the borrow.
        sum         = {1'b0, r0} - {1'b0, rn};
        {f_d, r0_d} = sum;
      end
      OP_AND: r0_d = r0 & rn;
      OP_OR:  r0_d = r0 | rn;
      OP_XOR: r0_d = r0 ^ rn;
      OP_SHL: begin
        f_d  = r0[DW-1];
        r0_d = {r0[DW-2:0], 1'b0};
      end
      OP_SHR: begin
        f_d  = r0[0];
        r0_d = {1'b0, r0[DW-1:1]};
      end
      OP_CMP: f_d = (r0 < rn);
      OP_BF:  if (f_q) pc_d = pc_q + br_off;
      OP_JMP: pc_d = rn_addr;
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (start) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      f_q     <= 1'b0;
      halt_q  <= 1'b0;
      ret_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      case (state_q)
        S_FETCH: state_q <= S_EXEC;
        S_EXEC: begin
          if (opc == OP_LD || opc == OP_ST) begin
            req_q   <= 1'b1;
            we_q    <= (opc == OP_ST);
            addr_q  <= rn_addr;
            wdata_q <= r0;
            state_q <= S_MEM;
          end else if (opc == OP_HALT) begin
            halt_q  <= 1'b1;
            ret_q   <= ret_inc;
            state_q <= S_HALTED;
          end else begin
            regs_q[0] <= r0_d;
            // STR r0 writes r0 back to itself, which is the required no-op.
            if (opc == OP_STR) regs_q[n] <= r0;
            f_q     <= f_d;
            pc_q    <= pc_d;
            ret_q   <= ret_inc;
            state_q <= S_FETCH;
          end
        end
        S_MEM: begin
          // Acks are only honoured here, so a late ack after reset is dropped.
          if (dmem.dmem_ack) begin
            req_q <= 1'b0;
            we_q  <= 1'b0;
            if (!we_q) regs_q[0] <= dmem.dmem_rdata;
            pc_q    <= pc_q + 1'b1;
            ret_q   <= ret_inc;
            state_q <= S_FETCH;
          end
        end
        S_HALTED: ;
        default: state_q <= S_FETCH;
      endcase
    end
  end

  assign imem_addr       = pc_q;
  assign pc              = pc_q;
  assign flag            = f_q;
  assign halt            = halt_q;
  assign retired         = ret_q;
  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;
endmodule

// File: tb/tb_mc_core.sv
// tb/tb_mc_core.sv - self-checking bench for mc_core
module tb_mc_core;
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        start = 1'b1, start2 = 1'b1;
  logic [7:0]  imem_addr, imem_addr2;
  logic [8:0]  imem_data = '0, imem_data2 = '0;
  logic        halt, flag, halt2, flag2;
  logic [7:0]  pc, pc2;
  logic [15:0] retired;
  logic [1:0]  retired2;

  mc_core_if #(.DW(8), .AW(8)) bus ();
  mc_core_if #(.DW(8), .AW(8)) bus2 ();

  mc_core #(.DW(8), .AW(8), .OPW(5), .RW(4), .CW(16)) dut (
    .CLK(CLK), .start(start), .imem_addr(imem_addr), .imem_data(imem_data),
    .dmem(bus), .halt(halt), .flag(flag), .pc(pc), .retired(retired)
  );

  mc_core #(.DW(8), .AW(8), .OPW(5), .RW(4), .CW(2)) dut2 (
    .CLK(CLK), .start(start2), .imem_addr(imem_addr2), .imem_data(imem_data2),
    .dmem(bus2), .halt(halt2), .flag(flag2), .pc(pc2), .retired(retired2)
  );

  logic [8:0] rom [256];
  always @(posedge CLK) begin
    imem_data  <= rom[imem_addr];
    imem_data2 <= rom[imem_addr2];
  end

  assign bus2.dmem_ack   = 1'b0;
  assign bus2.dmem_rdata = '0;

  // Data memory responder: random 0..3 extra wait cycles in auto mode,
  // or ack driven directly by the stimulus in manual mode.
  int         mem [256];
  logic       resp_en = 1'b1;
  logic       ack_man = 1'b0;
  logic       ack_auto = 1'b0;
  logic [7:0] rdata_r = '0;
  bit         busy = 1'b0;
  int         cnt = 0;

  assign bus.dmem_ack   = resp_en ? ack_auto : ack_man;
  assign bus.dmem_rdata = rdata_r;

  always @(negedge CLK) begin
    ack_auto = 1'b0;
    if (resp_en && bus.dmem_req) begin
      if (!busy) begin
        busy = 1'b1;
        cnt  = int'($urandom_range(0, 3));
      end
      if (cnt == 0) begin
        ack_auto = 1'b1;
        busy     = 1'b0;
        if (bus.dmem_we) mem[bus.dmem_addr] = int'(bus.dmem_wdata);
        else rdata_r = 8'(mem[bus.dmem_addr]);
      end else begin
        cnt--;
      end
    end else begin
      busy = 1'b0;
    end
  end

  int vectors = 0, miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_halt(input int max, output int cyc);
    cyc = 0;
    while (!halt && cyc < max) begin
      tick();
      cyc++;
    end
    check("halt_reached", 32'(halt), 32'd1);
  endtask

  task automatic wait_ret(input int n, input string tag);
    int c = 0;
    while (retired < 16'(n) && c < 300) begin
      tick();
      c++;
    end
    check(tag, 32'(retired >= 16'(n)), 32'd1);
  endtask

  function automatic logic [8:0] enc(input int op, input int n);
    return 9'(op * 16 + n);
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = '0;
  endtask

  // Instruction-level reference model: runs the program in rom to HALT.
  int m_r [16];
  int m_f, m_pc, m_ret;
  int mmem [256];

  task automatic model_run();
    int w, op, n, a, b, t, off;
    bit done;
    done = 1'b0;
    m_pc = 0; m_f = 0; m_ret = 0;
    for (int i = 0; i < 16; i++) m_r[i] = 0;
    for (int s = 0; s < 2000 && !done; s++) begin
      w = int'(rom[m_pc]);
      op = w / 16; n = w % 16;
      a = m_r[0]; b = m_r[n];
      m_ret++;
      case (op)
        0:  done = 1'b1;
        1:  m_r[0] = n;
        2:  m_r[0] = b;
        3:  m_r[n] = a;
        4:  begin t = a + b;       m_r[0] = t % 256; m_f = t / 256; end
        5:  begin t = a + b + m_f; m_r[0] = t % 256; m_f = t / 256; end
        6:  begin m_r[0] = (a - b + 256) % 256; m_f = (a < b) ? 1 : 0; end
        7:  m_r[0] = a & b;
        8:  m_r[0] = a | b;
        9:  m_r[0] = a ^ b;
        10: begin m_f = a / 128; m_r[0] = (a * 2) % 256; end
        11: begin m_f = a % 2;   m_r[0] = a / 2; end
        12: m_f = (a < b) ? 1 : 0;
        13: m_r[0] = mmem[b];
        14: mmem[b] = a;
        default: ;
      endcase
      if (op == 15) begin
        off = b % 16;
        if (off >= 8) off -= 16;
        m_pc = (m_f != 0) ? (m_pc + off + 256) % 256 : (m_pc + 1) % 256;
      end else if (op == 16) begin
        m_pc = b;
      end else if (op != 0) begin
        m_pc = (m_pc + 1) % 256;
      end
    end
  endtask

  int ops_tab [16] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 17, 31};

  initial begin
    int cyc, c, hi, bad, bad_h, bad_r, bad_p, nz;
    logic [7:0] pc_h;

    // Accumulate program, reset values and halt timing
    clear_rom();
    rom[0] = enc(1, 9); rom[1] = enc(3, 1); rom[2] = enc(1, 15);
    rom[3] = enc(4, 1); rom[4] = enc(0, 0);
    resp_en = 1'b1;
    do_reset();
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_retired", 32'(retired), 32'd0);
    check("rst_halt", 32'(halt), 32'd0);
    check("rst_flag", 32'(flag), 32'd0);
    check("rst_req", 32'(bus.dmem_req), 32'd0);
    check("rst_we", 32'(bus.dmem_we), 32'd0);
    check("rst_addr", 32'(bus.dmem_addr), 32'd0);
    check("rst_wdata", 32'(bus.dmem_wdata), 32'd0);
    check("rst_imem_addr", 32'(imem_addr), 32'd0);
    run_halt(100, cyc);
    check("t1_halt_cycles", 32'(cyc), 32'd10);
    check("t1_r0", 32'(dut.regs_q[0]), 32'h18);
    check("t1_flag", 32'(flag), 32'd0);
    check("t1_retired", 32'(retired), 32'd5);
    check("t1_pc", 32'(pc), 32'd4);

    // Idle while halted
    pc_h = pc; bad_h = 0; bad_r = 0; bad_p = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (!halt) bad_h++;
      if (bus.dmem_req) bad_r++;
      if (pc != pc_h) bad_p++;
    end
    check("halted_halt_drop", 32'(bad_h), 32'd0);
    check("halted_req", 32'(bad_r), 32'd0);
    check("halted_pc_move", 32'(bad_p), 32'd0);

    // Load then ADD/ADC with carry
    clear_rom();
    rom[0] = enc(1, 3); rom[1] = enc(3, 2); rom[2] = enc(13, 2);
    rom[3] = enc(3, 1); rom[4] = enc(4, 1); rom[5] = enc(5, 1); rom[6] = enc(0, 0);
    mem[3] = 'hF0;
    do_reset();
    wait_ret(5, "t2_wait_add");
    check("t2_add_r0", 32'(dut.regs_q[0]), 32'hE0);
    check("t2_add_f", 32'(flag), 32'd1);
    check("t2_r1", 32'(dut.regs_q[1]), 32'hF0);
    wait_ret(6, "t2_wait_adc");
    check("t2_adc_r0", 32'(dut.regs_q[0]), 32'hD1);
    check("t2_adc_f", 32'(flag), 32'd1);
    run_halt(50, cyc);

    // Backward branch from 0x10
    clear_rom();
    rom[0] = enc(1, 8); rom[1] = enc(10, 0); rom[2] = enc(3, 4); rom[3] = enc(1, 14);
    rom[4] = enc(3, 3); rom[5] = enc(1, 1); rom[6] = enc(12, 3); rom[7] = enc(16, 4);
    rom['h10] = enc(15, 3); rom['h0E] = enc(0, 0);
    do_reset();
    wait_ret(8, "t3a_wait_jmp");
    check("t3a_jmp_pc", 32'(pc), 32'h10);
    check("t3a_cmp_f", 32'(flag), 32'd1);
    wait_ret(9, "t3a_wait_bf");
    check("t3a_bf_pc", 32'(pc), 32'h0E);
    run_halt(50, cyc);
    check("t3a_retired", 32'(retired), 32'd10);

    // Branch not taken, then taken with wrap below zero
    clear_rom();
    rom[0] = enc(15, 3); rom[1] = enc(1, 15); rom[2] = enc(3, 3); rom[3] = enc(1, 1);
    rom[4] = enc(12, 3); rom[5] = enc(16, 5); rom['hFF] = enc(0, 0);
    do_reset();
    wait_ret(1, "t3b_wait_nt");
    check("t3b_nt_pc", 32'(pc), 32'd1);
    wait_ret(7, "t3b_wait_wrap");
    check("t3b_wrap_pc", 32'(pc), 32'hFF);
    run_halt(50, cyc);
    check("t3b_final_pc", 32'(pc), 32'hFF);
    check("t3b_retired", 32'(retired), 32'd8);

    // Store with three-cycle ack delay
    clear_rom();
    rom[0] = enc(1, 5); rom[1] = enc(3, 6); rom[2] = enc(1, 10);
    rom[3] = enc(14, 6); rom[4] = enc(0, 0);
    resp_en = 1'b0;
    do_reset();
    c = 0;
    while (!bus.dmem_req && c < 50) begin tick(); c++; end
    check("t4_req_seen", 32'(bus.dmem_req), 32'd1);
    check("t4_pc_at_req", 32'(pc), 32'd3);
    check("t4_ret_at_req", 32'(retired), 32'd3);
    hi = 0; bad = 0;
    for (int k = 0; k < 3; k++) begin
      if (bus.dmem_req) hi++;
      if (bus.dmem_addr != 8'd5 || bus.dmem_wdata != 8'd10 || bus.dmem_we != 1'b1 ||
          pc != 8'd3 || retired != 16'd3) bad++;
      if (k == 2) ack_man = 1'b1;
      tick();
    end
    ack_man = 1'b0;
    check("t4_req_cycles", 32'(hi), 32'd3);
    check("t4_stable", 32'(bad), 32'd0);
    check("t4_req_drop", 32'(bus.dmem_req), 32'd0);
    check("t4_pc_after", 32'(pc), 32'd4);
    check("t4_ret_after", 32'(retired), 32'd4);
    resp_en = 1'b1;
    run_halt(50, cyc);

    // Reset in the middle of a memory wait, then a stray ack
    clear_rom();
    rom[0] = enc(1, 7); rom[1] = enc(13, 0); rom[2] = enc(0, 0);
    resp_en = 1'b0;
    do_reset();
    c = 0;
    while (!bus.dmem_req && c < 50) begin tick(); c++; end
    tick(); tick();
    check("t5_waiting_req", 32'(bus.dmem_req), 32'd1);
    check("t5_waiting_pc", 32'(pc), 32'd1);
    check("t5_r0_before", 32'(dut.regs_q[0]), 32'd7);
    start = 1'b1;
    tick();
    check("t5_req", 32'(bus.dmem_req), 32'd0);
    check("t5_we", 32'(bus.dmem_we), 32'd0);
    check("t5_addr", 32'(bus.dmem_addr), 32'd0);
    check("t5_pc", 32'(pc), 32'd0);
    check("t5_retired", 32'(retired), 32'd0);
    nz = 0;
    for (int k = 0; k < 16; k++) if (dut.regs_q[k] != 8'd0) nz++;
    check("t5_regs_nonzero", 32'(nz), 32'd0);
    start = 1'b0;
    ack_man = 1'b1;
    tick();
    ack_man = 1'b0;
    check("t5_stray_pc", 32'(pc), 32'd0);
    check("t5_stray_ret", 32'(retired), 32'd0);
    tick();
    check("t5_restart_pc", 32'(pc), 32'd1);
    check("t5_restart_r0", 32'(dut.regs_q[0]), 32'd7);
    tick(); tick();
    check("t5_rereq", 32'(bus.dmem_req), 32'd1);
    check("t5_rereq_addr", 32'(bus.dmem_addr), 32'd7);
    resp_en = 1'b1;
    run_halt(50, cyc);

    // Saturating 2-bit retired counter
    start = 1'b1;
    clear_rom();
    for (int k = 0; k < 5; k++) rom[k] = enc(17, 0);
    rom[5] = enc(0, 0);
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    check("t6_rst_ret", 32'(retired2), 32'd0);
    c = 0;
    while (!halt2 && c < 100) begin tick(); c++; end
    check("t6_halt", 32'(halt2), 32'd1);
    check("t6_retired_sat", 32'(retired2), 32'd3);
    check("t6_pc", 32'(pc2), 32'd5);
    start2 = 1'b1;

    // Random straight-line programs against the reference model
    for (int p = 0; p < 20; p++) begin
      clear_rom();
      for (int i = 0; i < 24; i++)
        rom[i] = enc(ops_tab[$urandom_range(0, 15)], int'($urandom_range(0, 15)));
      for (int i = 0; i < 256; i++) begin
        mem[i]  = int'($urandom_range(0, 255));
        mmem[i] = mem[i];
      end
      model_run();
      resp_en = 1'b1;
      do_reset();
      run_halt(600, cyc);
      check("rnd_pc", 32'(pc), 32'(m_pc));
      check("rnd_flag", 32'(flag), 32'(m_f));
      check("rnd_retired", 32'(retired), 32'(m_ret));
      nz = 0;
      for (int k = 0; k < 16; k++) if (int'(dut.regs_q[k]) != m_r[k]) nz++;
      check("rnd_regs_diff", 32'(nz), 32'd0);
      nz = 0;
      for (int k = 0; k < 256; k++) if (mem[k] != mmem[k]) nz++;
      check("rnd_mem_diff", 32'(nz), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
